// File: rtl/median_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | median_window_feeder: 7-tap edge-replicated window builder around a        |
// | fixed-latency median filter, with a credit-protected result FIFO.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module median_window_feeder #(
    parameter int WIDTH      = 8,
    parameter int FILT_LAT   = 35,
    parameter int FIFO_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] win0,
    output logic [WIDTH-1:0] win1,
    output logic [WIDTH-1:0] win2,
    output logic [WIDTH-1:0] win3,
    output logic [WIDTH-1:0] win4,
    output logic [WIDTH-1:0] win5,
    output logic [WIDTH-1:0] win6,
    input  logic [WIDTH-1:0] filt_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q [7];
    logic [WIDTH-1:0]    sr_d [7];
    logic [2:0]          sh_q, sh_d;
    logic [LN_W-1:0]     n_in_q, n_in_d, n_out_q, n_out_d;
    logic                alive_q;
    logic [FILT_LAT-1:0] dl_vld_q, dl_vld_d, dl_last_q, dl_last_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]      fifo_mem [FIFO_DEPTH];

    logic             credit, accept, capture, pop, flush_go;
    logic             issue, issue_last, shift, load_all;
    logic [WIDTH-1:0] shift_in;

    // Credit counts the popped-this-cycle slot as still occupied, keeping the FIFO unable to overflow.
    assign credit   = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign accept   = s_valid & s_ready;
    assign capture  = dl_vld_q[FILT_LAT-1];
    assign pop      = m_valid & m_ready;
    assign flush_go = (state_q == ST_FLUSH) && ((sh_q < 3'd3) || credit);

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE:  s_ready = alive_q;
            ST_PRIME: s_ready = (sh_q < 3'd3) || credit;
            ST_RUN:   s_ready = credit;
            default:  s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        n_in_d     = n_in_q;
        n_out_d    = n_out_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        shift      = 1'b0;
        load_all   = 1'b0;
        shift_in   = s_data;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_all = 1'b1;
                    sh_d     = 3'd1;
                    n_in_d   = LN_W'(1);
                    n_out_d  = '0;
                    state_d  = s_last ? ST_FLUSH : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (accept) begin
                    shift  = 1'b1;
                    sh_d   = sh_q + 3'd1;
                    n_in_d = n_in_q + LN_W'(1);
                    if (sh_q == 3'd3) begin
                        issue   = 1'b1;
                        state_d = ST_RUN;
                    end
                    if (s_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    shift  = 1'b1;
                    issue  = 1'b1;
                    n_in_d = n_in_q + LN_W'(1);
                    if (s_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            default: begin
                if (flush_go) begin
                    shift    = 1'b1;
                    shift_in = sr_q[6];
                    if (sh_q < 3'd4) begin
                        sh_d = sh_q + 3'd1;
                    end
                    if (sh_q >= 3'd3) begin
                        issue      = 1'b1;
                        issue_last = ((n_out_q + LN_W'(1)) == n_in_q);
                        if (issue_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
        endcase
        if (issue) begin
            n_out_d = n_out_q + LN_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            sr_d[i] = load_all ? s_data : (shift ? sr_q[i+1] : sr_q[i]);
        end
        sr_d[6] = load_all ? s_data : (shift ? shift_in : sr_q[6]);
    end

    always_comb begin
        dl_vld_d   = {dl_vld_q[FILT_LAT-2:0], issue};
        dl_last_d  = {dl_last_q[FILT_LAT-2:0], issue_last};
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(capture);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(capture) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (capture) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            n_in_q     <= '0;
            n_out_q    <= '0;
            alive_q    <= 1'b0;
            dl_vld_q   <= '0;
            dl_last_q  <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < 7; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            n_in_q     <= n_in_d;
            n_out_q    <= n_out_d;
            alive_q    <= 1'b1;
            dl_vld_q   <= dl_vld_d;
            dl_last_q  <= dl_last_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < 7; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    // Storage needs no reset: entries are only visible while the occupancy count says so.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr_q] <= {filt_out, dl_last_q[FILT_LAT-1]};
        end
    end

    assign m_valid = (fifo_cnt_q != '0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr_q][WIDTH:1] : '0;
    assign m_last  = m_valid & fifo_mem[rd_ptr_q][0];

    assign win0 = sr_q[0];
    assign win1 = sr_q[1];
    assign win2 = sr_q[2];
    assign win3 = sr_q[3];
    assign win4 = sr_q[4];
    assign win5 = sr_q[5];
    assign win6 = sr_q[6];

endmodule
`default_nettype wire

// File: tb/tb_median_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_median_window_feeder: directed bench with behavioural median filter     |
// | and a result scoreboard.                                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_median_window_feeder;

    localparam int WIDTH      = 8;
    localparam int FILT_LAT   = 35;
    localparam int FIFO_DEPTH = 64;
    localparam int TMO        = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_last = 1'b0;
    logic [WIDTH-1:0] win0, win1, win2, win3, win4, win5, win6;
    logic [WIDTH-1:0] filt_out;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    median_window_feeder #(
        .WIDTH     (WIDTH),
        .FILT_LAT  (FILT_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .win0    (win0),
        .win1    (win1),
        .win2    (win2),
        .win3    (win3),
        .win4    (win4),
        .win5    (win5),
        .win6    (win6),
        .filt_out(filt_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] med7(input logic [7:0] a [7]);
        logic [7:0] s [7];
        logic [7:0] t;
        s = a;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 6 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t      = s[j];
                    s[j]   = s[j+1];
                    s[j+1] = t;
                end
            end
        end
        return s[3];
    endfunction

    // Behavioural filter: median of the window is valid FILT_LAT edges after the window updates.
    logic [7:0] wv [7];
    logic [7:0] fpipe [0:FILT_LAT-2];
    always_comb begin
        wv[0] = win0; wv[1] = win1; wv[2] = win2; wv[3] = win3;
        wv[4] = win4; wv[5] = win5; wv[6] = win6;
    end
    always @(posedge clk) begin
        fpipe[0] <= med7(wv);
        for (int i = 1; i < FILT_LAT - 1; i++) fpipe[i] <= fpipe[i-1];
    end
    assign filt_out = fpipe[FILT_LAT-2];

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         n_rx      = 0;
    int         n_acc     = 0;
    int         mv_seen   = 0;
    int         win_viol  = 0;
    int         first_mv  = -1;
    int         acc4_cyc  = 0;
    int         rx0, acc0;
    bit         chk_win   = 1'b0;
    logic [7:0] ln [$];
    logic [8:0] sb [$];
    logic [8:0] e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void push_line();
        int         n;
        int         j;
        logic [7:0] v [7];
        n = ln.size();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 7; k++) begin
                j = i + k - 3;
                if (j < 0) j = 0;
                if (j > n - 1) j = n - 1;
                v[k] = ln[j];
            end
            sb.push_back({(i == n - 1), med7(v)});
        end
    endfunction

    task automatic send(input logic [7:0] px, input logic lst);
        int t;
        t = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = px;
        s_last  = lst;
        while (!s_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            n_acc++;
            if (n_acc - acc0 == 4) acc4_cyc = cyc;
        end
    endtask

    task automatic send_line();
        for (int i = 0; i < ln.size(); i++) send(ln[i], (i == ln.size() - 1));
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < TMO) begin
            @(posedge clk);
            t++;
        end
        repeat (50) @(posedge clk);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    function automatic bit in_old(input logic [7:0] w);
        return (w >= 8'd10) && (w <= 8'd30);
    endfunction

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (rst && m_valid) mv_seen++;
                if (rst && m_valid && first_mv < 0) first_mv = cyc;
                if (rst && m_valid && m_ready) begin
                    n_rx++;
                    if (sb.size() == 0) begin
                        chk("unexpected_result_m_valid", {31'd0, m_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("m_data", {24'd0, m_data}, {24'd0, e[7:0]});
                        chk("m_last", {31'd0, m_last}, {31'd0, e[8]});
                    end
                end
                if (chk_win && (win3 == 8'd40 || win3 == 8'd50)) begin
                    if (in_old(win0) || in_old(win1) || in_old(win2) || in_old(win4) ||
                        in_old(win5) || in_old(win6)) win_viol++;
                end
            end
        join_none

        // Reset held with s_valid asserted
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'd5;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_win0", {24'd0, win0}, 32'd0);
        chk("rst_win1", {24'd0, win1}, 32'd0);
        chk("rst_win2", {24'd0, win2}, 32'd0);
        chk("rst_win3", {24'd0, win3}, 32'd0);
        chk("rst_win4", {24'd0, win4}, 32'd0);
        chk("rst_win5", {24'd0, win5}, 32'd0);
        chk("rst_win6", {24'd0, win6}, 32'd0);
        s_valid = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Seven-pixel line with an outlier, plus first-result latency
        m_ready  = 1'b1;
        first_mv = -1;
        acc0     = n_acc;
        rx0      = n_rx;
        ln = '{8'd0, 8'd1, 8'd2, 8'd30, 8'd4, 8'd5, 8'd6};
        push_line();
        send_line();
        drain("drain_line7");
        chk("line7_count", n_rx - rx0, 7);
        chk("first_result_latency", first_mv - acc4_cyc, FILT_LAT);

        // Back-to-back lines must not leak pixels across the boundary
        rx0      = n_rx;
        win_viol = 0;
        chk_win  = 1'b1;
        ln = '{8'd10, 8'd20, 8'd30};
        push_line();
        send_line();
        ln = '{8'd40, 8'd50};
        push_line();
        send_line();
        drain("drain_b2b");
        chk_win = 1'b0;
        chk("b2b_count", n_rx - rx0, 5);
        chk("b2b_window_leak", win_viol, 0);

        // Consumer stalled for 500 cycles while a 200-pixel line streams
        m_ready = 1'b0;
        acc0    = n_acc;
        rx0     = n_rx;
        ln.delete();
        for (int i = 0; i < 200; i++) ln.push_back(8'($urandom_range(0, 255)));
        push_line();
        fork
            send_line();
            begin
                repeat (500) @(posedge clk);
                #1;
                chk("stall_accepted", n_acc - acc0, FIFO_DEPTH + 3);
                chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
                chk("stall_m_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_no_output", n_rx - rx0, 0);
                m_ready = 1'b1;
            end
        join
        drain("drain_stall");
        chk("stall_count", n_rx - rx0, 200);

        // Reset mid-line with 20 windows in flight
        acc0 = n_acc;
        rx0  = n_rx;
        ln.delete();
        for (int i = 0; i < 30; i++) ln.push_back(8'($urandom_range(0, 255)));
        push_line();
        for (int i = 0; i < 23; i++) send(ln[i], 1'b0);
        rst     = 1'b0;
        s_valid = 1'b0;
        sb.delete();
        chk("midrst_accepted", n_acc - acc0, 23);
        chk("midrst_none_out_yet", n_rx - rx0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_win3", {24'd0, win3}, 32'd0);
        chk("midrst_win6", {24'd0, win6}, 32'd0);
        rst     = 1'b1;
        mv_seen = 0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_stale_m_valid", mv_seen, 0);

        // Single-pixel line after recovery
        rx0 = n_rx;
        ln = '{8'd9};
        push_line();
        send_line();
        drain("drain_single");
        chk("single_count", n_rx - rx0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
